alu_host_sequencer: RTL and testbench
=====================================

Name: alu_host_sequencer

Overview:
Host-side initiator for the 8-bit multi-cycle ALU's BEGIN/inbus/outbus/END protocol. It accepts an operation request on a valid/ready interface, pulses BEGIN and streams the operand words onto inbus in the fixed order. It then waits for END, captures the one- or two-word result from outbus and presents it on a valid/ready response interface. A watchdog aborts hung transactions.

Parameters:
TIMEOUT_CYCLES, 64, max cycles in WAIT before abort; legal range 2..255.
TMR_W, 8, watchdog counter width; must satisfy TIMEOUT_CYCLES < 2**TMR_W.

Ports:
clk  in  1  clock; all logic is on the rising edge
reset  in  1  synchronous, active-high
req_valid  in  1  request present
req_ready  out  1  sequencer accepts request
req_op  in  2  00 add, 01 sub, 10 multiply (radix-4), 11 divide (SRT-2)
req_x  in  8  add/sub: A operand; mul: multiplier Q; div: dividend high (A)
req_y  in  8  div: dividend low (Q); otherwise unused
req_m  in  8  M operand (addend/subtrahend/multiplicand/divisor)
BEGIN  out  1  one-cycle start pulse to ALU
op_code  out  2  opcode to ALU, held for whole transaction
inbus  out  8  operand words to ALU
outbus  in  8  result words from ALU
END  in  1  ALU completion strobe
rsp_valid  out  1  response present
rsp_ready  in  1  consumer accepts response
rsp_hi  out  8  mul: product high; div: remainder; add/sub: 0x00
rsp_lo  out  8  mul: product low; div: quotient; add/sub: result
rsp_timeout  out  1  response is an aborted transaction

Behaviour:
- Reset: state IDLE; req_ready=1, BEGIN=0, op_code=00, inbus=0x00, rsp_valid=0, rsp_hi=rsp_lo=0x00, rsp_timeout=0, watchdog=0, shadow=0x00. Reset in any state, including mid-send and WAIT, discards the transaction. No response is produced.
- States: IDLE, START, SEND, WAIT, RESP.
- IDLE: req_ready=1. When req_valid, latch op/x/y/m and go to START. req_ready is 0 in all other states.
- START (1 cycle): BEGIN=1, op_code=latched op. Go to SEND with word index 0.
- SEND: one word per cycle on inbus, BEGIN=0.
  - div: x, y, m (3 cycles).
  - mul: x, m (2 cycles).
  - add/sub: x, m (2 cycles).
  - After the last word go to WAIT, clear the watchdog and drive inbus=0x00.
- WAIT: register outbus into shadow every cycle. Watchdog increments each cycle.
  - END=1: rsp_lo=outbus.
    - mul/div: rsp_hi=shadow, i.e. the high word is on outbus the cycle before END.
    - add/sub: rsp_hi=0x00.
    - Set rsp_timeout=0 and go to RESP.
  - Watchdog reaches TIMEOUT_CYCLES without END: rsp_hi=rsp_lo=0xFF, rsp_timeout=1, go to RESP.
  - END in the same cycle the watchdog reaches its limit: END wins.
- RESP: rsp_valid=1; outputs stay stable until rsp_ready. On the handshake go to IDLE; rsp_valid drops the next cycle. A new request is accepted at the earliest one cycle after the response handshake.
- END outside WAIT is ignored. op_code holds its value from START through RESP and returns to 00 in IDLE.
- Latency, request accept to first possible response: 2 + words + ALU time.

Decomposition:
- Shared package alu_if_pkg:
  - opcode constants OP_ADD/OP_SUB/OP_MUL/OP_DIV;
  - state encoding;
  - per-op word-count constants: 2, 2, 2, 3.
- One natural sub-module, alu_watchdog_timer: clear, enable, terminal-count flag, parameterised by TIMEOUT_CYCLES and TMR_W.
- Bench ALU model: behavioural responder that drives the high word, then the low word with END, after a programmable delay.

Test Plan:
- Add: req op=00 x=0x05 m=0x03; model returns 0x08 with END after 10 cycles -> BEGIN is 1 cycle, inbus 0x05 then 0x03; rsp_hi=0x00, rsp_lo=0x08, rsp_timeout=0.
- Multiply: op=10 x=0x07 m=0x06; model drives 0x00 then 0x2A with END -> rsp_hi=0x00, rsp_lo=0x2A.
- Divide: op=11 x=0x00 y=0x64 m=0x07; inbus order 0x00, 0x64, 0x07; model returns 0x02 then 0x0E -> rsp_hi=0x02, rsp_lo=0x0E.
- Timeout: TIMEOUT_CYCLES=16, model never asserts END -> rsp_valid after exactly 16 WAIT cycles with 0xFF/0xFF and rsp_timeout=1. A repeat run with END on cycle 16 -> normal response.
- Backpressure: rsp_ready held low for 5 cycles -> rsp_* stable and req_ready=0 throughout; second request accepted one cycle after the handshake.
- Reset mid-WAIT: assert reset 3 cycles into WAIT, then a late END -> no rsp_valid, all outputs at reset values, next request completes normally.

Source files
------------

// File: rtl/alu_if_pkg.sv
// rtl/alu_if_pkg.sv - shared opcodes, state encoding and word counts for the ALU host sequencer
package alu_if_pkg;

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_MUL = 2'b10;
    localparam logic [1:0] OP_DIV = 2'b11;

    localparam logic [1:0] WORDS_ADD = 2'd2;
    localparam logic [1:0] WORDS_SUB = 2'd2;
    localparam logic [1:0] WORDS_MUL = 2'd2;
    localparam logic [1:0] WORDS_DIV = 2'd3;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_SEND,
        ST_WAIT,
        ST_RESP
    } seq_state_t;

    function automatic logic [1:0] op_words(input logic [1:0] op);
        logic [1:0] n;
        case (op)
            OP_ADD:  n = WORDS_ADD;
            OP_SUB:  n = WORDS_SUB;
            OP_MUL:  n = WORDS_MUL;
            default: n = WORDS_DIV;
        endcase
        return n;
    endfunction

    // Multiply and divide return a high word ahead of the END word.
    function automatic logic op_two_word(input logic [1:0] op);
        return (op == OP_MUL) || (op == OP_DIV);
    endfunction

endpackage

// File: rtl/alu_watchdog_timer.sv
// rtl/alu_watchdog_timer.sv - clearable up-counter flagging the cycle it reaches TIMEOUT_CYCLES
module alu_watchdog_timer #(
    parameter int TIMEOUT_CYCLES = 64,
    parameter int TMR_W          = 8
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic expire
);

    localparam logic [TMR_W-1:0] LAST = TMR_W'(TIMEOUT_CYCLES - 1);

    logic [TMR_W-1:0] count;

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            count <= '0;
        end else if (enable) begin
            count <= count + 1'b1;
        end
    end

    // Asserted during the enabled cycle whose increment reaches the limit.
    assign expire = enable && (count == LAST);

endmodule

// File: rtl/alu_host_sequencer.sv
// rtl/alu_host_sequencer.sv - host initiator for the multi-cycle ALU BEGIN/inbus/outbus/END protocol
module alu_host_sequencer
    import alu_if_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 64,
    parameter int TMR_W          = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       req_valid,
    output logic       req_ready,
    input  logic [1:0] req_op,
    input  logic [7:0] req_x,
    input  logic [7:0] req_y,
    input  logic [7:0] req_m,
    output logic       BEGIN,
    output logic [1:0] op_code,
    output logic [7:0] inbus,
    input  logic [7:0] outbus,
    input  logic       END,
    output logic       rsp_valid,
    input  logic       rsp_ready,
    output logic [7:0] rsp_hi,
    output logic [7:0] rsp_lo,
    output logic       rsp_timeout
);

    seq_state_t state;
    seq_state_t next_state;

    logic [1:0] op_q;
    logic [7:0] x_q;
    logic [7:0] y_q;
    logic [7:0] m_q;
    logic [1:0] idx;
    logic [7:0] shadow;
    logic       last_word;
    logic       wd_clear;
    logic       wd_enable;
    logic       wd_expire;

    assign last_word = (idx == (op_words(op_q) - 2'd1));

    alu_watchdog_timer #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES),
        .TMR_W         (TMR_W)
    ) u_watchdog (
        .clk   (clk),
        .reset (reset),
        .clear (wd_clear),
        .enable(wd_enable),
        .expire(wd_expire)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= ST_IDLE;
            op_q        <= OP_ADD;
            x_q         <= 8'h00;
            y_q         <= 8'h00;
            m_q         <= 8'h00;
            idx         <= 2'd0;
            shadow      <= 8'h00;
            rsp_hi      <= 8'h00;
            rsp_lo      <= 8'h00;
            rsp_timeout <= 1'b0;
        end else begin
            state <= next_state;
            case (state)
                ST_IDLE: begin
                    if (req_valid) begin
                        op_q <= req_op;
                        x_q  <= req_x;
                        y_q  <= req_y;
                        m_q  <= req_m;
                    end
                end
                ST_START: begin
                    idx <= 2'd0;
                end
                ST_SEND: begin
                    idx <= idx + 2'd1;
                end
                ST_WAIT: begin
                    shadow <= outbus;
                    // END takes priority over a watchdog expiring in the same cycle.
                    if (END) begin
                        rsp_lo      <= outbus;
                        rsp_hi      <= op_two_word(op_q) ? shadow : 8'h00;
                        rsp_timeout <= 1'b0;
                    end else if (wd_expire) begin
                        rsp_lo      <= 8'hFF;
                        rsp_hi      <= 8'hFF;
                        rsp_timeout <= 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    always_comb begin
        next_state = state;
        req_ready  = 1'b0;
        BEGIN      = 1'b0;
        op_code    = op_q;
        inbus      = 8'h00;
        rsp_valid  = 1'b0;
        wd_clear   = 1'b1;
        wd_enable  = 1'b0;
        case (state)
            ST_IDLE: begin
                req_ready = 1'b1;
                op_code   = OP_ADD;
                if (req_valid) begin
                    next_state = ST_START;
                end
            end
            ST_START: begin
                BEGIN      = 1'b1;
                next_state = ST_SEND;
            end
            ST_SEND: begin
                // Divide sends the dividend low word between A and M.
                case (idx)
                    2'd0:    inbus = x_q;
                    2'd1:    inbus = (op_q == OP_DIV) ? y_q : m_q;
                    default: inbus = m_q;
                endcase
                if (last_word) begin
                    next_state = ST_WAIT;
                end
            end
            ST_WAIT: begin
                wd_clear  = 1'b0;
                wd_enable = 1'b1;
                if (END || wd_expire) begin
                    next_state = ST_RESP;
                end
            end
            ST_RESP: begin
                rsp_valid = 1'b1;
                if (rsp_ready) begin
                    next_state = ST_IDLE;
                end
            end
            default: begin
                next_state = ST_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_alu_host_sequencer.sv
// tb/tb_alu_host_sequencer.sv - directed scoreboard bench for alu_host_sequencer with a behavioural ALU responder
module tb_alu_host_sequencer;
    import alu_if_pkg::*;

    localparam int TO = 16;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       req_valid = 1'b0;
    logic       req_ready;
    logic [1:0] req_op = 2'b00;
    logic [7:0] req_x = 8'h00;
    logic [7:0] req_y = 8'h00;
    logic [7:0] req_m = 8'h00;
    logic       alu_begin;
    logic [1:0] op_code;
    logic [7:0] inbus;
    logic [7:0] outbus = 8'h00;
    logic       alu_end = 1'b0;
    logic       rsp_valid;
    logic       rsp_ready = 1'b0;
    logic [7:0] rsp_hi;
    logic [7:0] rsp_lo;
    logic       rsp_timeout;

    always #5 clk = ~clk;

    alu_host_sequencer #(
        .TIMEOUT_CYCLES(TO),
        .TMR_W         (8)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_op     (req_op),
        .req_x      (req_x),
        .req_y      (req_y),
        .req_m      (req_m),
        .BEGIN      (alu_begin),
        .op_code    (op_code),
        .inbus      (inbus),
        .outbus     (outbus),
        .END        (alu_end),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_hi     (rsp_hi),
        .rsp_lo     (rsp_lo),
        .rsp_timeout(rsp_timeout)
    );

    typedef struct {
        logic [7:0] hi;
        logic [7:0] lo;
        logic       to;
        int         lat;
    } exp_t;

    exp_t       exp_q[$];
    logic [7:0] exp_words[$];
    logic [7:0] got_words[$];
    int         total = 0;
    int         bad = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // ALU responder: records operand words, drives the high word one cycle before the low word with END.
    int         m_delay = 10;
    logic [7:0] m_hi = 8'h00;
    logic [7:0] m_lo = 8'h00;
    bit         m_no_end = 1'b0;
    bit         m_busy = 1'b0;
    int         m_cnt = 0;
    int         m_words = 2;

    always @(negedge clk) begin
        alu_end = 1'b0;
        if (alu_begin) begin
            m_busy  = 1'b1;
            m_cnt   = 0;
            m_words = (op_code == OP_DIV) ? 3 : 2;
        end else if (m_busy) begin
            m_cnt++;
            if (m_cnt <= m_words) got_words.push_back(inbus);
            if (!m_no_end) begin
                if (m_cnt == m_words + m_delay - 1) outbus = m_hi;
                if (m_cnt == m_words + m_delay) begin
                    outbus  = m_lo;
                    alu_end = 1'b1;
                    m_busy  = 1'b0;
                end
            end
        end
    end

    task automatic check_reset_outputs(input string tag);
        check({tag, "_req_ready"}, 32'(req_ready), 32'd1);
        check({tag, "_begin"}, 32'(alu_begin), 32'd0);
        check({tag, "_op_code"}, 32'(op_code), 32'd0);
        check({tag, "_inbus"}, 32'(inbus), 32'h00);
        check({tag, "_rsp_valid"}, 32'(rsp_valid), 32'd0);
        check({tag, "_rsp_hi_lo"}, {16'h0, rsp_hi, rsp_lo}, 32'h0000);
        check({tag, "_rsp_timeout"}, 32'(rsp_timeout), 32'd0);
    endtask

    // Called just after a negedge with the DUT idle; returns just after the negedge following the handshake.
    task automatic run_txn(input string tag, input logic [1:0] op, input logic [7:0] x, input logic [7:0] y,
                           input logic [7:0] m, input logic [7:0] mhi, input logic [7:0] mlo, input int delay,
                           input bit no_end, input logic [7:0] ehi, input logic [7:0] elo, input logic eto,
                           input int hold);
        int   nw;
        int   lat;
        int   extra_begin;
        exp_t e;
        nw = (op == OP_DIV) ? 3 : 2;
        m_delay  = delay;
        m_hi     = mhi;
        m_lo     = mlo;
        m_no_end = no_end;
        exp_q.push_back('{hi: ehi, lo: elo, to: eto, lat: 2 + nw + delay});
        exp_words.push_back(x);
        if (op == OP_DIV) exp_words.push_back(y);
        exp_words.push_back(m);

        check({tag, "_req_ready"}, 32'(req_ready), 32'd1);
        req_valid = 1'b1;
        req_op    = op;
        req_x     = x;
        req_y     = y;
        req_m     = m;
        @(negedge clk);
        req_valid = 1'b0;
        check({tag, "_begin"}, 32'(alu_begin), 32'd1);
        check({tag, "_op_code"}, 32'(op_code), 32'(op));
        check({tag, "_busy"}, 32'(req_ready), 32'd0);

        lat = 1;
        extra_begin = 0;
        while (!rsp_valid && lat < 200) begin
            @(negedge clk);
            lat++;
            if (alu_begin) extra_begin++;
        end
        check({tag, "_rsp_valid"}, 32'(rsp_valid), 32'd1);
        if (!rsp_valid) return;

        e = exp_q.pop_front();
        check({tag, "_latency"}, 32'(lat), 32'(e.lat));
        check({tag, "_rsp_hi"}, 32'(rsp_hi), 32'(e.hi));
        check({tag, "_rsp_lo"}, 32'(rsp_lo), 32'(e.lo));
        check({tag, "_rsp_timeout"}, 32'(rsp_timeout), 32'(e.to));
        check({tag, "_begin_once"}, 32'(extra_begin), 32'd0);
        check({tag, "_op_hold"}, 32'(op_code), 32'(op));
        check({tag, "_inbus_idle"}, 32'(inbus), 32'h00);
        check({tag, "_word_count"}, 32'(got_words.size()), 32'(nw));
        for (int i = 0; i < nw; i++) begin
            logic [7:0] w;
            w = (got_words.size() > 0) ? got_words.pop_front() : 8'hxx;
            check({tag, "_inbus_word"}, 32'(w), 32'(exp_words.pop_front()));
        end

        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            check({tag, "_hold_valid"}, 32'(rsp_valid), 32'd1);
            check({tag, "_hold_data"}, {15'h0, rsp_timeout, rsp_hi, rsp_lo}, {15'h0, e.to, e.hi, e.lo});
            check({tag, "_hold_ready"}, 32'(req_ready), 32'd0);
        end

        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        check({tag, "_rsp_drop"}, 32'(rsp_valid), 32'd0);
        check({tag, "_op_idle"}, 32'(op_code), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL global_time_limit observed=expired expected=finish");
        $fatal(1, "time limit");
    end

    initial begin
        int seen;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        check_reset_outputs("reset");

        run_txn("add", OP_ADD, 8'h05, 8'h00, 8'h03, 8'h5A, 8'h08, 10, 1'b0, 8'h00, 8'h08, 1'b0, 0);
        run_txn("sub", OP_SUB, 8'h09, 8'h00, 8'h04, 8'h77, 8'h05, 3, 1'b0, 8'h00, 8'h05, 1'b0, 0);
        run_txn("mul", OP_MUL, 8'h07, 8'h00, 8'h06, 8'h00, 8'h2A, 5, 1'b0, 8'h00, 8'h2A, 1'b0, 0);
        run_txn("mul_hi", OP_MUL, 8'h20, 8'h00, 8'h10, 8'h02, 8'h00, 2, 1'b0, 8'h02, 8'h00, 1'b0, 0);
        run_txn("div", OP_DIV, 8'h00, 8'h64, 8'h07, 8'h02, 8'h0E, 6, 1'b0, 8'h02, 8'h0E, 1'b0, 0);
        run_txn("timeout", OP_ADD, 8'h11, 8'h00, 8'h22, 8'h00, 8'h00, TO, 1'b1, 8'hFF, 8'hFF, 1'b1, 0);
        run_txn("end_at_limit", OP_MUL, 8'h0F, 8'h00, 8'h11, 8'h3C, 8'hC3, TO, 1'b0, 8'h3C, 8'hC3, 1'b0, 0);
        run_txn("backpressure", OP_DIV, 8'h01, 8'h00, 8'h10, 8'h00, 8'h10, 4, 1'b0, 8'h00, 8'h10, 1'b0, 5);
        run_txn("after_bp", OP_ADD, 8'h01, 8'h00, 8'h01, 8'h00, 8'h02, 2, 1'b0, 8'h00, 8'h02, 1'b0, 0);

        // Abort three cycles into WAIT; the responder still fires END later while idle.
        m_delay  = 10;
        m_hi     = 8'h11;
        m_lo     = 8'h22;
        m_no_end = 1'b0;
        req_valid = 1'b1;
        req_op    = OP_MUL;
        req_x     = 8'h33;
        req_m     = 8'h44;
        @(negedge clk);
        req_valid = 1'b0;
        repeat (5) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check_reset_outputs("mid_wait_reset");
        seen = 0;
        repeat (15) begin
            @(negedge clk);
            if (rsp_valid || alu_begin) seen++;
        end
        check("late_end_ignored", 32'(seen), 32'd0);
        check_reset_outputs("after_late_end");
        check("aborted_words", 32'(got_words.size()), 32'd2);
        got_words.delete();

        run_txn("post_reset", OP_SUB, 8'h40, 8'h00, 8'h01, 8'h00, 8'h3F, 4, 1'b0, 8'h00, 8'h3F, 1'b0, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
